// File: rtl/multi_channel_shift_fifo_pkg.sv
// Shared types and helpers for the multi-channel shift-register FIFO.
package shift_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/multi_channel_shift_fifo_channel.sv
// Single-channel WIDTH x DEPTH shift FIFO with occupancy, level flags and sticky errors.
// Optional SHIFT_FIFO_BYPASS_EN: push+pop on an empty channel passes data_in straight through.
module shift_fifo_channel
  import shift_fifo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt;
  err_flags_t       err;
  logic             is_empty;
  logic             is_full;
  logic             bypass;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CW'(DEPTH));

`ifdef SHIFT_FIFO_BYPASS_EN
  assign bypass = push & pop & is_empty;
`else
  assign bypass = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!bypass) begin
      if (pop && !is_empty) begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i + 1];
        mem[DEPTH-1] <= '0;
        // with a concurrent push the new word lands in the slot the shift just opened
        if (push) begin
          for (int unsigned i = 0; i < DEPTH; i++)
            if (CW'(i + 1) == cnt) mem[i] <= data_in;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end else if (push && !is_full) begin
        for (int unsigned i = 0; i < DEPTH; i++)
          if (CW'(i) == cnt) mem[i] <= data_in;
        cnt <= cnt + CW'(1);
        if (pop) err.underflow <= 1'b1;
      end else if (push) begin
        err.overflow <= 1'b1;
      end else if (pop) begin
        err.underflow <= 1'b1;
      end
    end
  end

  assign data_out     = bypass ? data_in : mem[0];
  assign empty        = is_empty;
  assign full         = is_full;
  assign almost_full  = (int'(cnt) >= AF_LVL);
  assign almost_empty = (int'(cnt) <= AE_LVL);
  assign count        = cnt;
  assign overflow     = err.overflow;
  assign underflow    = err.underflow;

endmodule

// File: rtl/multi_channel_shift_fifo.sv
// NCH independent shift FIFOs behind flattened per-channel vectors.
// Optional SHIFT_FIFO_BYPASS_EN is honoured inside each channel.
module multi_channel_shift_fifo
  import shift_fifo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NCH    = 2,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     push,
  input  logic [NCH-1:0]     pop,
  input  logic [NCH*WIDTH-1:0] data_in,
  output logic [NCH*WIDTH-1:0] data_out,
  output logic [NCH-1:0]     empty,
  output logic [NCH-1:0]     full,
  output logic [NCH-1:0]     almost_full,
  output logic [NCH-1:0]     almost_empty,
  output logic [NCH*CW-1:0]  count,
  output logic [NCH-1:0]     overflow,
  output logic [NCH-1:0]     underflow
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    shift_fifo_channel #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .AF_LVL (AF_LVL),
      .AE_LVL (AE_LVL)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .push         (push[c]),
      .pop          (pop[c]),
      .data_in      (data_in[c*WIDTH +: WIDTH]),
      .data_out     (data_out[c*WIDTH +: WIDTH]),
      .empty        (empty[c]),
      .full         (full[c]),
      .almost_full  (almost_full[c]),
      .almost_empty (almost_empty[c]),
      .count        (count[c*CW +: CW]),
      .overflow     (overflow[c]),
      .underflow    (underflow[c])
    );
  end

endmodule

// File: tb/tb_multi_channel_shift_fifo.sv
// Directed self-checking bench for multi_channel_shift_fifo (WIDTH=8, DEPTH=4, NCH=2).
module tb_multi_channel_shift_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  push, pop;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic [1:0]  empty, full, almost_full, almost_empty, overflow, underflow;
  logic [5:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  multi_channel_shift_fifo #(
    .WIDTH (8),
    .DEPTH (4),
    .NCH   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .data_out     (data_out),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; push = '0; pop = '0; data_in = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (count !== 6'd0) begin n_fail++; $display("FAIL rst_count: got %h want 00", count); end
    n_tests++; if (empty !== 2'b11) begin n_fail++; $display("FAIL rst_empty: got %b want 11", empty); end
    n_tests++; if ({full, almost_full} !== 4'b0000) begin n_fail++; $display("FAIL rst_full_af: got %b want 0000", {full, almost_full}); end
    n_tests++; if (almost_empty !== 2'b11) begin n_fail++; $display("FAIL rst_ae: got %b want 11", almost_empty); end
    n_tests++; if ({overflow, underflow} !== 4'b0000) begin n_fail++; $display("FAIL rst_err: got %b want 0000", {overflow, underflow}); end
    n_tests++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL rst_dout: got %h want 0000", data_out); end
  endtask

  task automatic test_push_ch0();
    logic [7:0] vals [3];
    vals[0] = 8'hA1; vals[1] = 8'hB2; vals[2] = 8'hC3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push = 2'b01; data_in = {8'h00, vals[i]};
      tick();
      n_tests++; if (count[2:0] !== 3'(i + 1)) begin n_fail++; $display("FAIL push_cnt%0d: got %0d want %0d", i, count[2:0], i + 1); end
      n_tests++; if (data_out[7:0] !== 8'hA1) begin n_fail++; $display("FAIL push_head%0d: got %h want a1", i, data_out[7:0]); end
    end
    push = '0;
    n_tests++; if (empty[1] !== 1'b1 || count[5:3] !== 3'd0) begin n_fail++; $display("FAIL push_ch1_idle: empty=%b count=%0d want 1/0", empty[1], count[5:3]); end
    n_tests++; if (almost_full[0] !== 1'b1 || full[0] !== 1'b0) begin n_fail++; $display("FAIL push_af3: af=%b full=%b want 1/0", almost_full[0], full[0]); end
  endtask

  task automatic test_reset_midop();
    // ch0 still holds A1,B2,C3 from the previous scenario
    push = 2'b01; data_in = 16'h00D4; rst = 1'b1;
    tick();
    rst = 1'b0; push = '0;
    n_tests++; if (count[2:0] !== 3'd0 || empty[0] !== 1'b1) begin n_fail++; $display("FAIL midrst: count=%0d empty=%b want 0/1", count[2:0], empty[0]); end
    n_tests++; if (data_out[7:0] !== 8'h00) begin n_fail++; $display("FAIL midrst_dout: got %h want 00", data_out[7:0]); end
    tick();
    n_tests++; if (count[2:0] !== 3'd0) begin n_fail++; $display("FAIL midrst_lost: got %0d want 0", count[2:0]); end
  endtask

  task automatic test_overflow_ch1();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push = 2'b10; data_in = {8'(8'h10 + i), 8'h00};
      tick();
      if (i == 2) begin
        n_tests++; if (almost_full[1] !== 1'b1 || full[1] !== 1'b0) begin n_fail++; $display("FAIL ovf_af: af=%b full=%b want 1/0", almost_full[1], full[1]); end
      end
    end
    n_tests++; if (full[1] !== 1'b1 || count[5:3] !== 3'd4) begin n_fail++; $display("FAIL ovf_full: full=%b count=%0d want 1/4", full[1], count[5:3]); end
    push = 2'b10; data_in = 16'h9900;
    tick();
    push = '0;
    n_tests++; if (count[5:3] !== 3'd4) begin n_fail++; $display("FAIL ovf_cnt: got %0d want 4", count[5:3]); end
    n_tests++; if (overflow !== 2'b10) begin n_fail++; $display("FAIL ovf_flag: got %b want 10", overflow); end
    n_tests++; if (data_out[15:8] !== 8'h10) begin n_fail++; $display("FAIL ovf_head: got %h want 10", data_out[15:8]); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h03; exp_seq[1] = 8'h04; exp_seq[2] = 8'h55; exp_seq[3] = 8'h00;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push = 2'b01; data_in = {8'h00, 8'(i + 1)};
      tick();
    end
    push = 2'b01; pop = 2'b01; data_in = 16'h0055;
    tick();
    push = '0;
    n_tests++; if (count[2:0] !== 3'd4 || full[0] !== 1'b1) begin n_fail++; $display("FAIL pp_full_cnt: count=%0d full=%b want 4/1", count[2:0], full[0]); end
    n_tests++; if (data_out[7:0] !== 8'h02) begin n_fail++; $display("FAIL pp_full_head: got %h want 02", data_out[7:0]); end
    for (int i = 0; i < 4; i++) begin
      pop = 2'b01;
      tick();
      n_tests++; if (data_out[7:0] !== exp_seq[i] || count[2:0] !== 3'(3 - i)) begin n_fail++; $display("FAIL pp_drain%0d: dout=%h count=%0d want %h/%0d", i, data_out[7:0], count[2:0], exp_seq[i], 3 - i); end
    end
    pop = '0;
    n_tests++; if (empty[0] !== 1'b1 || underflow[0] !== 1'b0) begin n_fail++; $display("FAIL pp_empty: empty=%b udf=%b want 1/0", empty[0], underflow[0]); end
  endtask

  task automatic test_underflow();
    do_reset();
    pop = 2'b01;
    tick();
    pop = '0;
    n_tests++; if (count[2:0] !== 3'd0 || underflow !== 2'b01) begin n_fail++; $display("FAIL udf_set: count=%0d udf=%b want 0/01", count[2:0], underflow); end
    tick(); tick();
    n_tests++; if (underflow[0] !== 1'b1) begin n_fail++; $display("FAIL udf_sticky: got %b want 1", underflow[0]); end
    do_reset();
    n_tests++; if (underflow[0] !== 1'b0) begin n_fail++; $display("FAIL udf_clear: got %b want 0", underflow[0]); end
  endtask

  task automatic test_empty_push_pop();
    do_reset();
    push = 2'b10; pop = 2'b10; data_in = 16'h7E00;
`ifdef SHIFT_FIFO_BYPASS_EN
    #1;
    n_tests++; if (data_out[15:8] !== 8'h7E) begin n_fail++; $display("FAIL byp_same: got %h want 7e", data_out[15:8]); end
    tick();
    push = '0; pop = '0;
    n_tests++; if (count[5:3] !== 3'd0 || underflow[1] !== 1'b0) begin n_fail++; $display("FAIL byp_state: count=%0d udf=%b want 0/0", count[5:3], underflow[1]); end
`else
    tick();
    push = '0; pop = '0;
    n_tests++; if (count[5:3] !== 3'd1 || underflow[1] !== 1'b1) begin n_fail++; $display("FAIL epp_state: count=%0d udf=%b want 1/1", count[5:3], underflow[1]); end
    n_tests++; if (data_out[15:8] !== 8'h7E) begin n_fail++; $display("FAIL epp_head: got %h want 7e", data_out[15:8]); end
`endif
  endtask

  initial begin
    rst = 1'b1; push = '0; pop = '0; data_in = '0;
    test_reset();
    test_push_ch0();
    test_reset_midop();
    test_overflow_ch1();
    test_push_pop_full();
    test_underflow();
    test_empty_push_pop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
